// File: rtl/timekeeper_if.sv
// Control/load/status bundle for the timekeeper HH:MM:SS counter.
interface timekeeper_if #(
  parameter int SEC_W  = 6,
  parameter int MIN_W  = 6,
  parameter int HOUR_W = 5
);
  logic              tick_i;
  logic              count_enable_i;
  logic              down_i;
  logic              load_time_i;
  logic [SEC_W-1:0]  load_seconds_i;
  logic [MIN_W-1:0]  load_minutes_i;
  logic [HOUR_W-1:0] load_hours_i;
  logic [SEC_W-1:0]  seconds_o;
  logic [MIN_W-1:0]  minutes_o;
  logic [HOUR_W-1:0] hours_o;
  logic              sec_wrap_o;
  logic              min_wrap_o;
  logic              hour_wrap_o;
  logic              load_error_o;
  logic              done_o;
  logic              expired_o;

  modport master (
    output tick_i, count_enable_i, down_i, load_time_i,
           load_seconds_i, load_minutes_i, load_hours_i,
    input  seconds_o, minutes_o, hours_o, sec_wrap_o, min_wrap_o,
           hour_wrap_o, load_error_o, done_o, expired_o
  );

  modport slave (
    input  tick_i, count_enable_i, down_i, load_time_i,
           load_seconds_i, load_minutes_i, load_hours_i,
    output seconds_o, minutes_o, hours_o, sec_wrap_o, min_wrap_o,
           hour_wrap_o, load_error_o, done_o, expired_o
  );
endinterface

// File: rtl/timekeeper.sv
// Loadable up/down HH:MM:SS counter with cascading wrap pulses and an
// optional halt-at-zero countdown mode.
module timekeeper #(
  parameter int SEC_MOD      = 60,
  parameter int MIN_MOD      = 60,
  parameter int HOUR_MOD     = 24,
  parameter int SEC_W        = 6,
  parameter int MIN_W        = 6,
  parameter int HOUR_W       = 5,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic        clk_100MHz_i,
  input  logic        reset_i,
  timekeeper_if.slave bus
);

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(MIN_MOD - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

  typedef enum logic {COUNT, EXPIRED} state_t;
  state_t state_q, state_d;

  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic sec_wrap_d, min_wrap_d, hour_wrap_d, load_err_d, done_d;
  logic load_ok, qtick, near_zero;

  // Compare one bit wider so a modulus of exactly 2^W still fits.
  assign load_ok = ({1'b0, bus.load_seconds_i} < (SEC_W+1)'(SEC_MOD)) &&
                   ({1'b0, bus.load_minutes_i} < (MIN_W+1)'(MIN_MOD)) &&
                   ({1'b0, bus.load_hours_i}   < (HOUR_W+1)'(HOUR_MOD));
  assign qtick     = bus.tick_i && bus.count_enable_i;
  assign near_zero = (hour_q == '0) && (min_q == '0) && (sec_q <= SEC_W'(1));

  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) state_q <= COUNT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sec_wrap_d  = 1'b0;
    min_wrap_d  = 1'b0;
    hour_wrap_d = 1'b0;
    load_err_d  = 1'b0;
    done_d      = 1'b0;
    if (bus.load_time_i) begin
      if (load_ok) begin
        sec_d   = bus.load_seconds_i;
        min_d   = bus.load_minutes_i;
        hour_d  = bus.load_hours_i;
        state_d = COUNT;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (qtick && state_q == COUNT) begin
      if (!bus.down_i) begin
        if (sec_q == SEC_MAX) begin
          sec_d = '0; sec_wrap_d = 1'b1;
          if (min_q == MIN_MAX) begin
            min_d = '0; min_wrap_d = 1'b1;
            if (hour_q == HOUR_MAX) begin
              hour_d = '0; hour_wrap_d = 1'b1;
            end else hour_d = hour_q + HOUR_W'(1);
          end else min_d = min_q + MIN_W'(1);
        end else sec_d = sec_q + SEC_W'(1);
      end else if (STOP_AT_ZERO && near_zero) begin
        // Landing on (or sitting at) zero ends the countdown without borrows.
        sec_d   = '0;
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        if (sec_q == '0) begin
          sec_d = SEC_MAX; sec_wrap_d = 1'b1;
          if (min_q == '0) begin
            min_d = MIN_MAX; min_wrap_d = 1'b1;
            if (hour_q == '0) begin
              hour_d = HOUR_MAX; hour_wrap_d = 1'b1;
            end else hour_d = hour_q - HOUR_W'(1);
          end else min_d = min_q - MIN_W'(1);
        end else sec_d = sec_q - SEC_W'(1);
      end
    end
  end

  always_comb begin
    bus.expired_o = (state_q == EXPIRED);
  end

  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      sec_q            <= '0;
      min_q            <= '0;
      hour_q           <= '0;
      bus.sec_wrap_o   <= 1'b0;
      bus.min_wrap_o   <= 1'b0;
      bus.hour_wrap_o  <= 1'b0;
      bus.load_error_o <= 1'b0;
      bus.done_o       <= 1'b0;
    end else begin
      sec_q            <= sec_d;
      min_q            <= min_d;
      hour_q           <= hour_d;
      bus.sec_wrap_o   <= sec_wrap_d;
      bus.min_wrap_o   <= min_wrap_d;
      bus.hour_wrap_o  <= hour_wrap_d;
      bus.load_error_o <= load_err_d;
      bus.done_o       <= done_d;
    end
  end

  assign bus.seconds_o = sec_q;
  assign bus.minutes_o = min_q;
  assign bus.hours_o   = hour_q;

endmodule
